operand_entry_buffer: RTL and testbench

Parametrised keypad entry buffer for the calculator datapath. Collects BCD digits for two operands and one operator from debounced keypad events, then presents the completed expression to the arithmetic unit via a valid/ready handshake. It sits between the keypad decoder and the ALU/display path, replacing the fixed 3-digit entry memory, and adds digit-count tracking, overflow flagging, clear, result handshake and optional backspace.

---
 rtl/operand_entry_buffer_if.sv | 32 +++
 rtl/operand_entry_buffer.sv | 152 +++++++++++++++
 tb/tb_operand_entry_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_buffer_if.sv
// Keypad-to-ALU bundle for the operand entry buffer: key events in, completed expression out.
// The master side is the keypad decoder plus ALU; the slave side is the buffer itself.
interface operand_entry_buffer_if #(
    parameter int DIGITS = 3
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  key_is_op;
    logic                  key_back;
    logic                  key_clear;
    logic                  calc_ready;
    logic [2:0]            entry_state;
    logic [1:0]            operator;
    logic [4*DIGITS-1:0]   number1;
    logic [4*DIGITS-1:0]   number2;
    logic [CW-1:0]         count1;
    logic [CW-1:0]         count2;
    logic                  overflow;
    logic                  calc_valid;

    modport master (
        output key_valid, key_code, key_is_op, key_back, key_clear, calc_ready,
        input  entry_state, operator, number1, number2, count1, count2, overflow, calc_valid
    );

    modport slave (
        input  key_valid, key_code, key_is_op, key_back, key_clear, calc_ready,
        output entry_state, operator, number1, number2, count1, count2, overflow, calc_valid
    );
endinterface

// File: rtl/operand_entry_buffer.sv
// Collects two BCD operands and an operator from keypad events and hands the expression to the ALU.
// Optional feature: define ENTRY_BACKSPACE_EN to make key_back events delete the last entry.
module operand_entry_buffer #(
    parameter int DIGITS = 3
) (
    input  logic                    Clock_1ms,
    input  logic                    Reset,
    operand_entry_buffer_if.slave   bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NUM1 = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_NUM2 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [1:0]          operator_q, operator_d;
    logic [4*DIGITS-1:0] number1_q, number1_d;
    logic [4*DIGITS-1:0] number2_q, number2_d;
    logic [CW-1:0]       count1_q, count1_d;
    logic [CW-1:0]       count2_q, count2_d;
    logic                overflow_q, overflow_d;
    logic                hist_q, hist_d;

    logic                key_event;
    logic                is_digit;
    logic [4*DIGITS-1:0] shift1, shift2;

    assign key_event = bus.key_valid & ~hist_q;
    assign is_digit  = (bus.key_code <= 4'd9);
    assign hist_d    = bus.key_valid;

    always_comb begin
        shift1      = number1_q << 4;
        shift1[3:0] = bus.key_code;
        shift2      = number2_q << 4;
        shift2[3:0] = bus.key_code;
    end

    always_comb begin
        state_d    = state_q;
        operator_d = operator_q;
        number1_d  = number1_q;
        number2_d  = number2_q;
        count1_d   = count1_q;
        count2_d   = count2_q;
        overflow_d = overflow_q;

        // Clear and the accepted handshake both return every output to its reset value.
        if (bus.key_clear || (state_q == S_DONE && bus.calc_ready)) begin
            state_d    = S_IDLE;
            operator_d = 2'd0;
            number1_d  = '0;
            number2_d  = '0;
            count1_d   = '0;
            count2_d   = '0;
            overflow_d = 1'b0;
        end else if (key_event && state_q != S_DONE) begin
`ifdef ENTRY_BACKSPACE_EN
            if (bus.key_back) begin
                case (state_q)
                    S_NUM1: begin
                        number1_d = number1_q >> 4;
                        count1_d  = count1_q - ONE;
                        if (count1_q == ONE) state_d = S_IDLE;
                    end
                    S_NUM2: begin
                        number2_d = number2_q >> 4;
                        count2_d  = count2_q - ONE;
                        if (count2_q == ONE) state_d = S_OP;
                    end
                    S_OP: begin
                        operator_d = 2'd0;
                        state_d    = (count1_q == '0) ? S_IDLE : S_NUM1;
                    end
                    default: ;
                endcase
            end else
`endif
            if (bus.key_is_op) begin
                if (bus.key_code <= 4'd3) begin
                    if (state_q == S_IDLE || state_q == S_NUM1 || state_q == S_OP) begin
                        operator_d = bus.key_code[1:0];
                        state_d    = S_OP;
                    end
                end else if (bus.key_code == 4'hE) begin
                    if (state_q == S_OP) begin
                        number2_d = '0;
                        count2_d  = '0;
                        state_d   = S_DONE;
                    end else if (state_q == S_NUM2) begin
                        state_d = S_DONE;
                    end
                end
            end else if (is_digit) begin
                if (state_q == S_IDLE || state_q == S_NUM1) begin
                    if (count1_q == FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        number1_d = shift1;
                        count1_d  = count1_q + ONE;
                    end
                    state_d = S_NUM1;
                end else begin
                    if (count2_q == FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        number2_d = shift2;
                        count2_d  = count2_q + ONE;
                    end
                    state_d = S_NUM2;
                end
            end
        end
    end

    // History resets high so a key already held at reset release is not taken as an event.
    always_ff @(posedge Clock_1ms or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            operator_q <= 2'd0;
            number1_q  <= '0;
            number2_q  <= '0;
            count1_q   <= '0;
            count2_q   <= '0;
            overflow_q <= 1'b0;
            hist_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            operator_q <= operator_d;
            number1_q  <= number1_d;
            number2_q  <= number2_d;
            count1_q   <= count1_d;
            count2_q   <= count2_d;
            overflow_q <= overflow_d;
            hist_q     <= hist_d;
        end
    end

    assign bus.entry_state = state_q;
    assign bus.operator    = operator_q;
    assign bus.number1     = number1_q;
    assign bus.number2     = number2_q;
    assign bus.count1      = count1_q;
    assign bus.count2      = count2_q;
    assign bus.overflow    = overflow_q;
    assign bus.calc_valid  = (state_q == S_DONE);
endmodule

// File: tb/tb_operand_entry_buffer.sv
// Directed bench for operand_entry_buffer (DIGITS = 3); expectations adapt to ENTRY_BACKSPACE_EN.
module tb_operand_entry_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    operand_entry_buffer_if #(.DIGITS(3)) bus ();

    operand_entry_buffer #(.DIGITS(3)) dut (
        .Clock_1ms (clk),
        .Reset     (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One key event: strobe high for one cycle, then low for one cycle.
    task automatic key(input logic [3:0] code, input logic is_op, input logic back);
        @(negedge clk);
        bus.key_code  = code;
        bus.key_is_op = is_op;
        bus.key_back  = back;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_back  = 1'b0;
        $display("key code=%h op=%0b back=%0b -> state=%0d n1=%h n2=%h c1=%0d c2=%0d opr=%0d ovf=%0b",
                 code, is_op, back, bus.entry_state, bus.number1, bus.number2,
                 bus.count1, bus.count2, bus.operator, bus.overflow);
    endtask

    task automatic clear_all();
        @(negedge clk);
        bus.key_clear = 1'b1;
        @(negedge clk);
        bus.key_clear = 1'b0;
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.key_is_op  = 1'b0;
        bus.key_back   = 1'b0;
        bus.key_clear  = 1'b0;
        bus.calc_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_state", 32'(bus.entry_state), 32'd0);
        chk("rst_n1", 32'(bus.number1), 32'h0);
        chk("rst_valid", 32'(bus.calc_valid), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full expression 123 + 45 =
        key(4'd1, 1'b0, 1'b0);
        chk("first_digit", 32'(bus.number1), 32'h001);
        key(4'd2, 1'b0, 1'b0);
        key(4'd3, 1'b0, 1'b0);
        chk("n1_123", 32'(bus.number1), 32'h123);
        chk("c1_3", 32'(bus.count1), 32'd3);
        chk("state_num1", 32'(bus.entry_state), 32'd1);
        key(4'd0, 1'b1, 1'b0);
        chk("state_op", 32'(bus.entry_state), 32'd2);
        chk("opr_plus", 32'(bus.operator), 32'd0);
        key(4'd4, 1'b0, 1'b0);
        key(4'd5, 1'b0, 1'b0);
        chk("n2_045", 32'(bus.number2), 32'h045);
        chk("c2_2", 32'(bus.count2), 32'd2);
        chk("state_num2", 32'(bus.entry_state), 32'd3);
        key(4'hE, 1'b1, 1'b0);
        chk("state_done", 32'(bus.entry_state), 32'd4);
        chk("valid_done", 32'(bus.calc_valid), 32'd1);
        repeat (2) @(negedge clk);
        chk("valid_hold", 32'(bus.calc_valid), 32'd1);
        bus.calc_ready = 1'b1;
        @(negedge clk);
        bus.calc_ready = 1'b0;
        $display("handshake -> state=%0d n1=%h valid=%0b", bus.entry_state, bus.number1, bus.calc_valid);
        chk("hs_valid", 32'(bus.calc_valid), 32'd0);
        chk("hs_state", 32'(bus.entry_state), 32'd0);
        chk("hs_n1", 32'(bus.number1), 32'h0);
        chk("hs_n2", 32'(bus.number2), 32'h0);
        chk("hs_c1", 32'(bus.count1), 32'd0);

        // Overflow on a fourth digit
        key(4'd9, 1'b0, 1'b0);
        key(4'd8, 1'b0, 1'b0);
        key(4'd7, 1'b0, 1'b0);
        chk("ovf_before", 32'(bus.overflow), 32'd0);
        key(4'd6, 1'b0, 1'b0);
        chk("ovf_n1", 32'(bus.number1), 32'h987);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_c1", 32'(bus.count1), 32'd3);

        // Clear beats a concurrent key event
        @(negedge clk);
        bus.key_clear = 1'b1;
        bus.key_code  = 4'd4;
        bus.key_is_op = 1'b0;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_clear = 1'b0;
        bus.key_valid = 1'b0;
        $display("clear+key -> state=%0d n1=%h ovf=%0b", bus.entry_state, bus.number1, bus.overflow);
        chk("clr_n1", 32'(bus.number1), 32'h0);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_c1", 32'(bus.count1), 32'd0);
        chk("clr_state", 32'(bus.entry_state), 32'd0);

        // key_valid held high 20 cycles gives one digit
        @(negedge clk);
        bus.key_code  = 4'd4;
        bus.key_valid = 1'b1;
        repeat (20) @(negedge clk);
        bus.key_valid = 1'b0;
        @(negedge clk);
        $display("held key 4 -> n1=%h c1=%0d", bus.number1, bus.count1);
        chk("held_n1", 32'(bus.number1), 32'h004);
        chk("held_c1", 32'(bus.count1), 32'd1);
        clear_all();

        // 5 x / = : operator replaced, number2 empty, DONE frozen
        key(4'd5, 1'b0, 1'b0);
        key(4'd2, 1'b1, 1'b0);
        chk("opr_mul", 32'(bus.operator), 32'd2);
        key(4'd3, 1'b1, 1'b0);
        key(4'hE, 1'b1, 1'b0);
        chk("div_opr", 32'(bus.operator), 32'd3);
        chk("div_n2", 32'(bus.number2), 32'h0);
        chk("div_state", 32'(bus.entry_state), 32'd4);
        key(4'd7, 1'b0, 1'b0);
        chk("done_n2_frozen", 32'(bus.number2), 32'h0);
        chk("done_n1_frozen", 32'(bus.number1), 32'h005);
        chk("done_state_kept", 32'(bus.entry_state), 32'd4);
        repeat (5) @(negedge clk);
        chk("done_valid_wait", 32'(bus.calc_valid), 32'd1);

        // Async reset in DONE; key held across release gives no event
        bus.key_code  = 4'd6;
        bus.key_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        $display("async reset in DONE -> state=%0d valid=%0b", bus.entry_state, bus.calc_valid);
        chk("arst_valid", 32'(bus.calc_valid), 32'd0);
        chk("arst_state", 32'(bus.entry_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_noevent_n1", 32'(bus.number1), 32'h0);
        chk("arst_noevent_c1", 32'(bus.count1), 32'd0);
        bus.key_valid = 1'b0;

        // Backspace sequence
        key(4'd1, 1'b0, 1'b0);
        key(4'd2, 1'b0, 1'b0);
        key(4'hF, 1'b0, 1'b1);
`ifdef ENTRY_BACKSPACE_EN
        chk("bs_n1", 32'(bus.number1), 32'h001);
        chk("bs_c1", 32'(bus.count1), 32'd1);
`else
        chk("bs_n1", 32'(bus.number1), 32'h012);
        chk("bs_c1", 32'(bus.count1), 32'd2);
`endif
        key(4'd0, 1'b1, 1'b0);
        key(4'hF, 1'b0, 1'b1);
`ifdef ENTRY_BACKSPACE_EN
        chk("bs_op_state", 32'(bus.entry_state), 32'd1);
`else
        chk("bs_op_state", 32'(bus.entry_state), 32'd2);
`endif
        chk("bs_opr", 32'(bus.operator), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
